uart_tx_regs: RTL and testbench

- Register-bus mapped, parametrised UART transmitter with a TX FIFO.
- Programmable character size (5–8 bits), parity (none/even/odd) and stop bits (1/2).
- Baud divisor is software-programmable.
- Sits between the 8-bit register bus (write_enable/address/data_in/data_out) and the serial tx line; it is the configurable successor to the fixed-format UART datapath.

---
 rtl/uart_tx_regs.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx_regs.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_regs.sv
// uart_tx_regs: register-mapped UART transmitter with a small TX FIFO.
// Frame format (5-8 data bits, none/even/odd parity, 1/2 stop bits) and the
// baud divisor are set through five byte-wide registers starting at BASE_ADDR.
module uart_tx_regs #(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 8,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              tx,
   output logic              tx_busy,
   output logic              fifo_empty
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // Address decode: hit[n] is set when the bus addresses register BASE_ADDR+n
   logic [4:0] hit;
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_decode
         assign hit[gi] = (address == BASE_ADDR + ADDR_W'(gi));
      end
   endgenerate

   logic wr_ubrrl, wr_ubrrh, wr_ctrl, wr_status, wr_data;
   assign wr_ubrrl  = write_enable && hit[0];
   assign wr_ubrrh  = write_enable && hit[1];
   assign wr_ctrl   = write_enable && hit[2];
   assign wr_status = write_enable && hit[3];
   assign wr_data   = write_enable && hit[4];

   // Configuration and status registers
   logic [15:0] ubrr_reg;
   logic [5:0]  ctrl_reg;
   logic        overflow_reg;

   // FIFO storage and bookkeeping
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             fifo_full, push, drop, pop;

   // Transmit engine state; frame configuration is captured at pop time
   state_t      state_reg;
   logic [7:0]  shift_reg;
   logic [15:0] baud_cnt_reg;
   logic [2:0]  bit_cnt_reg;
   logic        stop_cnt_reg;
   logic        par_acc_reg, par_en_reg, par_odd_reg, stop2_reg;
   logic [1:0]  size_reg;
   logic        tx_reg;

   logic bit_end, last_bit, last_stop, can_start;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == FULL_COUNT);
   // Full is judged before any same-cycle pop, so a push into a full FIFO drops
   assign push       = wr_data && !fifo_full;
   assign drop       = wr_data && fifo_full;

   assign bit_end   = (baud_cnt_reg == 16'd0);
   assign last_bit  = (bit_cnt_reg == ({1'b0, size_reg} + 3'd4));
   assign last_stop = !stop2_reg || stop_cnt_reg;
   assign can_start = ctrl_reg[0] && !fifo_empty;
   // Pop from IDLE, or straight out of the final stop bit for back-to-back frames
   assign pop = can_start &&
                ((state_reg == S_IDLE) ||
                 ((state_reg == S_STOP) && bit_end && last_stop));

   assign tx      = tx_reg;
   assign tx_busy = (state_reg != S_IDLE);

   // Register read mux; unmapped and write-only locations read as zero
   always_comb begin
      data_out = '0;
      if (hit[0])
         data_out = DATA_W'(ubrr_reg[7:0]);
      else if (hit[1])
         data_out = DATA_W'(ubrr_reg[15:8]);
      else if (hit[2])
         data_out = DATA_W'({2'b00, ctrl_reg});
      else if (hit[3])
         data_out = DATA_W'({4'b0000, overflow_reg, tx_busy, fifo_full, fifo_empty});
   end

   // Software-visible registers: divisor, control and the sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ubrr_reg     <= '0;
         ctrl_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_ubrrl) ubrr_reg[7:0]  <= data_in[7:0];
         if (wr_ubrrh) ubrr_reg[15:8] <= data_in[7:0];
         if (wr_ctrl)  ctrl_reg       <= data_in[5:0];
         if (drop)
            overflow_reg <= 1'b1;
         else if (wr_status && data_in[3])
            overflow_reg <= 1'b0;
      end
   end

   // FIFO storage write; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= data_in[7:0];
   end

   // FIFO pointers and occupancy count; pointers wrap naturally at FIFO_DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Frame FSM; tx is registered from the current state so it trails the state by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         tx_reg       <= 1'b1;
         shift_reg    <= '0;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         par_acc_reg  <= 1'b0;
         par_en_reg   <= 1'b0;
         par_odd_reg  <= 1'b0;
         stop2_reg    <= 1'b0;
         size_reg     <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               tx_reg <= 1'b1;
            end
            S_START: begin
               tx_reg <= 1'b0;
               if (bit_end) begin
                  baud_cnt_reg <= ubrr_reg;
                  state_reg    <= S_DATA;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 16'd1;
               end
            end
            S_DATA: begin
               tx_reg <= shift_reg[0];
               if (bit_end) begin
                  baud_cnt_reg <= ubrr_reg;
                  par_acc_reg  <= par_acc_reg ^ shift_reg[0];
                  shift_reg    <= shift_reg >> 1;
                  bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                  if (last_bit) state_reg <= par_en_reg ? S_PARITY : S_STOP;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 16'd1;
               end
            end
            S_PARITY: begin
               tx_reg <= par_acc_reg ^ par_odd_reg;
               if (bit_end) begin
                  baud_cnt_reg <= ubrr_reg;
                  state_reg    <= S_STOP;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 16'd1;
               end
            end
            S_STOP: begin
               tx_reg <= 1'b1;
               if (bit_end) begin
                  if (!last_stop) begin
                     stop_cnt_reg <= 1'b1;
                     baud_cnt_reg <= ubrr_reg;
                  end else begin
                     state_reg <= S_IDLE;
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 16'd1;
               end
            end
            default: begin
               tx_reg    <= 1'b1;
               state_reg <= S_IDLE;
            end
         endcase
         // A pop loads the next character and its frame format, overriding the above
         if (pop) begin
            state_reg    <= S_START;
            shift_reg    <= fifo_mem[rd_ptr_reg];
            baud_cnt_reg <= ubrr_reg;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            par_acc_reg  <= 1'b0;
            par_en_reg   <= ctrl_reg[2];
            par_odd_reg  <= ctrl_reg[1];
            stop2_reg    <= ctrl_reg[3];
            size_reg     <= ctrl_reg[5:4];
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_regs.sv
// tb_uart_tx_regs: directed self-checking bench for uart_tx_regs.
module tb_uart_tx_regs;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       write_enable = 1'b0;
   logic [7:0] address = 8'h10;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       tx;
   logic       tx_busy;
   logic       fifo_empty;

   int checks = 0;
   int errors = 0;
   int busy_cnt = 0;
   int low_cnt = 0;

   uart_tx_regs #(
      .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .BASE_ADDR(8'h00)
   ) dut (
      .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .address(address),
      .data_in(data_in), .data_out(data_out), .tx(tx), .tx_busy(tx_busy),
      .fifo_empty(fifo_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      write_enable = 1'b1;
      address      = a;
      data_in      = d;
      @(negedge clk);
      write_enable = 1'b0;
      address      = 8'h10;
      $display("write addr=%02h data=%02h", a, d);
   endtask

   task automatic check_reg(input logic [7:0] a, input logic [7:0] exp, input string tag);
      address = a;
      #1;
      check(tag, 16'(data_out), 16'(exp));
      $display("read  addr=%02h data=%02h (%s)", a, data_out, tag);
      address = 8'h10;
   endtask

   // First cycle after the DATA/CTRL write edge: line still idle
   task automatic start_frames(input string tag);
      @(negedge clk);
      check({tag, "_idle_pre"}, 16'(tx), 16'd1);
      busy_cnt = int'(tx_busy);
   endtask

   // seq[0] is the start bit; each bit is held for 'period' clocks
   task automatic run_frame(input logic [15:0] seq, input int nbits, input int period,
                            input string tag);
      for (int b = 0; b < nbits; b++) begin
         for (int p = 0; p < period; p++) begin
            @(negedge clk);
            check($sformatf("%s_b%0d_c%0d", tag, b, p), 16'(tx), 16'(seq[b]));
            busy_cnt += int'(tx_busy);
         end
      end
      $display("frame %s done (%0d bits x %0d clks)", tag, nbits, period);
   endtask

   task automatic end_frames(input int exp_busy, input string tag);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("%s_idle_post%0d", tag, i), 16'(tx), 16'd1);
         busy_cnt += int'(tx_busy);
      end
      check({tag, "_busy_clks"}, 16'(busy_cnt), 16'(exp_busy));
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_tx", 16'(tx), 16'd1);
      check("rst_busy", 16'(tx_busy), 16'd0);
      check("rst_empty", 16'(fifo_empty), 16'd1);
      rst_n = 1'b1;
      check_reg(8'h00, 8'h00, "rst_ubrrl");
      check_reg(8'h01, 8'h00, "rst_ubrrh");
      check_reg(8'h02, 8'h00, "rst_ctrl");
      check_reg(8'h03, 8'h01, "rst_status");

      // CTRL bits 7:6 read back as zero
      bus_write(8'h02, 8'hFF);
      check_reg(8'h02, 8'h3F, "ctrl_mask");
      bus_write(8'h01, 8'hA7);
      check_reg(8'h01, 8'hA7, "ubrrh_rw");
      bus_write(8'h01, 8'h00);

      // 8N1, divisor 3: 40-clock frame of 8'hA5
      bus_write(8'h00, 8'h03);
      bus_write(8'h02, 8'h31);
      bus_write(8'h04, 8'hA5);
      start_frames("f8n1");
      run_frame({1'b1, 8'hA5, 1'b0}, 10, 4, "f8n1");
      end_frames(40, "f8n1");
      check_reg(8'h03, 8'h01, "f8n1_status");

      // 7E1 and 7O1, divisor 1, data 8'h55
      bus_write(8'h00, 8'h01);
      bus_write(8'h02, 8'h25);
      bus_write(8'h04, 8'h55);
      start_frames("f7e1");
      run_frame({1'b1, 1'b0, 7'h55, 1'b0}, 10, 2, "f7e1");
      end_frames(20, "f7e1");
      bus_write(8'h02, 8'h27);
      bus_write(8'h04, 8'h55);
      start_frames("f7o1");
      run_frame({1'b1, 1'b1, 7'h55, 1'b0}, 10, 2, "f7o1");
      end_frames(20, "f7o1");

      // 5N2, divisor 0: upper three bits of 8'hFF are not sent
      bus_write(8'h00, 8'h00);
      bus_write(8'h02, 8'h09);
      bus_write(8'h04, 8'hFF);
      start_frames("f5n2");
      run_frame({2'b11, 5'h1F, 1'b0}, 8, 1, "f5n2");
      end_frames(8, "f5n2");

      // Overflow with transmitter disabled, then four back-to-back frames
      bus_write(8'h02, 8'h30);
      for (int i = 1; i <= 5; i++) bus_write(8'h04, 8'(i));
      check_reg(8'h03, 8'h0A, "ovf_status");
      check("ovf_empty_pin", 16'(fifo_empty), 16'd0);
      bus_write(8'h02, 8'h31);
      start_frames("b2b");
      for (int k = 1; k <= 4; k++)
         run_frame({1'b1, 8'(k), 1'b0}, 10, 1, $sformatf("b2b%0d", k));
      end_frames(40, "b2b");
      check_reg(8'h03, 8'h09, "ovf_sticky");
      bus_write(8'h03, 8'hF7);
      check_reg(8'h03, 8'h09, "ovf_write0");
      bus_write(8'h03, 8'h08);
      check_reg(8'h03, 8'h01, "ovf_clear");

      // Unmapped and write-only locations
      bus_write(8'h00, 8'h12);
      check_reg(8'h05, 8'h00, "rd_base5");
      check_reg(8'h04, 8'h00, "rd_data");
      bus_write(8'h07, 8'hFF);
      check_reg(8'h00, 8'h12, "wr7_ubrrl");
      check_reg(8'h01, 8'h00, "wr7_ubrrh");
      check_reg(8'h02, 8'h31, "wr7_ctrl");
      check_reg(8'h03, 8'h01, "wr7_status");

      // Reset 10 clocks into an 8'hA5 frame, with a second byte still queued
      bus_write(8'h00, 8'h03);
      bus_write(8'h04, 8'hA5);
      bus_write(8'h04, 8'h5A);
      repeat (9) @(negedge clk);
      check("mid_tx_low", 16'(tx), 16'd0);
      check("mid_queued", 16'(fifo_empty), 16'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", 16'(tx), 16'd1);
      check("mid_rst_busy", 16'(tx_busy), 16'd0);
      check("mid_rst_empty", 16'(fifo_empty), 16'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_reg(8'h03, 8'h01, "post_rst_status");
      check_reg(8'h02, 8'h00, "post_rst_ctrl");
      bus_write(8'h02, 8'h31);
      low_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) low_cnt++;
      end
      check("post_rst_no_tx", 16'(low_cnt), 16'd0);
      check("post_rst_empty", 16'(fifo_empty), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
